// File: rtl/guess_scorer_pkg.sv
// Shared definitions for the guess scorer.
//   state_e     : 2-bit FSM state encoding (S_WAIT/S_SPIN/S_SHOW/S_OVER)
//   DEF_NUM_POS : default number of spinner positions
//   DEF_POS_W   : default width of the spinner position bus
package guess_scorer_pkg;

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_SPIN = 2'd1,
    S_SHOW = 2'd2,
    S_OVER = 2'd3
  } state_e;

  localparam int DEF_NUM_POS = 6;
  localparam int DEF_POS_W   = 3;

endpackage

// File: rtl/guess_scorer_popcount.sv
// guess_popcount: combinational count of set bits in the guess vector.
//   guess_i : NUM_POS-bit player guess
//   cnt_o   : number of bits set in guess_i
module guess_popcount #(
  parameter int NUM_POS = 6,
  parameter int CNT_W   = $clog2(NUM_POS + 1)
) (
  input  logic [NUM_POS-1:0] guess_i,
  output logic [CNT_W-1:0]   cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < NUM_POS; i++) cnt_o = cnt_o + CNT_W'(guess_i[i]);
  end

endmodule

// File: rtl/guess_scorer.sv
// guess_scorer: scores each spinner stop against the player's guess over a
// fixed-length game and drives the 7-seg decimal point.
//   clk_i/rst_i  : clock, synchronous active-high reset
//   pos_i        : current spinner position
//   running_i    : 1 = spinning, 0 = stopped
//   guess_i      : one bit per position
//   clear_i      : new-game request
//   dp_o         : decimal point (solid hit, blinking miss, game-over verdict)
//   hit_o/miss_o : 1-cycle result pulses, first show cycle
//   score_o/streak_o/rounds_o : game counters
//   game_over_o  : high while the game is finished
module guess_scorer
  import guess_scorer_pkg::*;
#(
  parameter int NUM_POS    = DEF_NUM_POS,
  parameter int POS_W      = DEF_POS_W,
  parameter int MAX_PICKS  = 1,
  parameter int ROUNDS     = 8,
  parameter int SCORE_W    = 4,
  parameter int SHOW_CYC   = 16,
  parameter int BLINK_LOG2 = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [POS_W-1:0]   pos_i,
  input  logic               running_i,
  input  logic [NUM_POS-1:0] guess_i,
  input  logic               clear_i,
  output logic               dp_o,
  output logic               hit_o,
  output logic               miss_o,
  output logic [SCORE_W-1:0] score_o,
  output logic [SCORE_W-1:0] streak_o,
  output logic [SCORE_W-1:0] rounds_o,
  output logic               game_over_o
);

  localparam int CNT_W = $clog2(NUM_POS + 1);
  // Counter must be wide enough for both the show length and the blink tap.
  localparam int SHOW_W = ($clog2(SHOW_CYC) > BLINK_LOG2) ? $clog2(SHOW_CYC) : BLINK_LOG2 + 1;
  localparam logic [SHOW_W-1:0]  SHOW_INIT = SHOW_W'(SHOW_CYC - 1);
  localparam logic [SCORE_W-1:0] ROUNDS_C  = SCORE_W'(ROUNDS);
  localparam logic [SCORE_W-1:0] SAT_MAX   = '1;

  state_e             state_q, state_d;
  logic [SHOW_W-1:0]  show_cnt_q, show_cnt_d;
  logic [SCORE_W-1:0] score_q, score_d, streak_q, streak_d, rounds_q, rounds_d;
  logic               hit_q, hit_d, hit_p_q, hit_p_d, miss_p_q, miss_p_d;

  logic [CNT_W-1:0]      picks;
  logic [2**POS_W-1:0]   guess_ext;
  logic                  hit, stop_evt, last_round;

  guess_popcount #(.NUM_POS(NUM_POS), .CNT_W(CNT_W)) u_pop (
    .guess_i (guess_i),
    .cnt_o   (picks)
  );

  // Zero-extend the guess so an out-of-range position indexes a 0 bit.
  always_comb begin
    guess_ext = '0;
    guess_ext[NUM_POS-1:0] = guess_i;
  end

  assign hit = ({1'b0, pos_i} < (POS_W+1)'(NUM_POS)) && guess_ext[pos_i] &&
               (picks <= CNT_W'(MAX_PICKS));
  assign stop_evt   = (state_q == S_SPIN) && !running_i;
  assign last_round = (rounds_q == ROUNDS_C);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clear_i) state_d = running_i ? S_SPIN : S_WAIT;
    else begin
      case (state_q)
        S_WAIT: if (running_i) state_d = S_SPIN;
        S_SPIN: if (!running_i) state_d = S_SHOW;
        S_SHOW: if (running_i || show_cnt_q == '0)
                  state_d = last_round ? S_OVER : (running_i ? S_SPIN : S_WAIT);
        default: state_d = S_OVER;
      endcase
    end
  end

  // Counters and result latches
  always_comb begin
    show_cnt_d = show_cnt_q;
    score_d    = score_q;
    streak_d   = streak_q;
    rounds_d   = rounds_q;
    hit_d      = hit_q;
    hit_p_d    = 1'b0;
    miss_p_d   = 1'b0;
    if (clear_i) begin
      show_cnt_d = '0;
      score_d    = '0;
      streak_d   = '0;
      rounds_d   = '0;
      hit_d      = 1'b0;
    end else if (stop_evt) begin
      show_cnt_d = SHOW_INIT;
      hit_d      = hit;
      hit_p_d    = hit;
      miss_p_d   = !hit;
      if (hit && score_q != SAT_MAX) score_d = score_q + SCORE_W'(1);
      if (!hit) streak_d = '0;
      else if (streak_q != SAT_MAX) streak_d = streak_q + SCORE_W'(1);
      if (!last_round) rounds_d = rounds_q + SCORE_W'(1);
    end else if (state_q == S_SHOW && show_cnt_q != '0) begin
      show_cnt_d = show_cnt_q - SHOW_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_WAIT;
      show_cnt_q <= '0;
      score_q    <= '0;
      streak_q   <= '0;
      rounds_q   <= '0;
      hit_q      <= 1'b0;
      hit_p_q    <= 1'b0;
      miss_p_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      show_cnt_q <= show_cnt_d;
      score_q    <= score_d;
      streak_q   <= streak_d;
      rounds_q   <= rounds_d;
      hit_q      <= hit_d;
      hit_p_q    <= hit_p_d;
      miss_p_q   <= miss_p_d;
    end
  end

  // dp depends only on flops, so it is as clean as a registered output.
  always_comb begin
    case (state_q)
      S_SPIN:  dp_o = 1'b0;
      S_SHOW:  dp_o = hit_q | show_cnt_q[BLINK_LOG2];
      S_OVER:  dp_o = ({score_q, 1'b0} >= (SCORE_W+1)'(ROUNDS));
      default: dp_o = hit_q;
    endcase
  end

  assign hit_o       = hit_p_q;
  assign miss_o      = miss_p_q;
  assign score_o     = score_q;
  assign streak_o    = streak_q;
  assign rounds_o    = rounds_q;
  assign game_over_o = (state_q == S_OVER);

endmodule

// File: tb/tb_guess_scorer.sv
module tb_guess_scorer;

  logic       clk = 1'b0;
  logic       rst1, rst2, running, clear;
  logic [2:0] pos;
  logic [5:0] guess;

  logic       dp1, hit1, miss1, go1;
  logic [3:0] score1, streak1, rounds1;
  logic       dp2, hit2, miss2, go2;
  logic [1:0] score2, streak2, rounds2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  guess_scorer dut1 (
    .clk_i(clk), .rst_i(rst1), .pos_i(pos), .running_i(running), .guess_i(guess),
    .clear_i(clear), .dp_o(dp1), .hit_o(hit1), .miss_o(miss1), .score_o(score1),
    .streak_o(streak1), .rounds_o(rounds1), .game_over_o(go1)
  );

  guess_scorer #(.SCORE_W(2), .ROUNDS(3)) dut2 (
    .clk_i(clk), .rst_i(rst2), .pos_i(pos), .running_i(running), .guess_i(guess),
    .clear_i(clear), .dp_o(dp2), .hit_o(hit2), .miss_o(miss2), .score_o(score2),
    .streak_o(streak2), .rounds_o(rounds2), .game_over_o(go2)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // From S_WAIT: one cycle spinning, then stop at p with guess g.
  // Returns in the first show cycle.
  task automatic spin_stop(input logic [2:0] p, input logic [5:0] g);
    running = 1'b1;
    tick(1);
    running = 1'b0;
    pos     = p;
    guess   = g;
    tick(1);
  endtask

  task automatic chk1(input string tag, input logic h, input logic m, input int s,
                      input int st, input int r, input logic d, input logic go);
    chk({tag, ".hit"},    32'(hit1),    32'(h));
    chk({tag, ".miss"},   32'(miss1),   32'(m));
    chk({tag, ".score"},  32'(score1),  32'(s));
    chk({tag, ".streak"}, 32'(streak1), 32'(st));
    chk({tag, ".rounds"}, 32'(rounds1), 32'(r));
    chk({tag, ".dp"},     32'(dp1),     32'(d));
    chk({tag, ".over"},   32'(go1),     32'(go));
  endtask

  initial begin
    rst1 = 1'b1; rst2 = 1'b1; running = 1'b0; clear = 1'b0; pos = '0; guess = '0;
    tick(2);
    chk1("reset", 0, 0, 0, 0, 0, 0, 0);
    rst1 = 1'b0;

    // 1: hit at pos 2
    spin_stop(3'd2, 6'b000100);
    chk1("t1_show", 1, 0, 1, 1, 1, 1, 0);
    tick(1);
    chk("t1_pulse_end", 32'(hit1), 32'd0);
    chk("t1_dp_show", 32'(dp1), 32'd1);
    tick(15);
    chk1("t1_wait", 0, 0, 1, 1, 1, 1, 0);

    // 2: miss at pos 4, blink pattern from counter bit 2 (15..0)
    spin_stop(3'd4, 6'b000100);
    chk1("t2_show", 0, 1, 1, 0, 2, 1, 0);
    tick(3);  chk("t2_dp_c12", 32'(dp1), 32'd1);
    tick(1);  chk("t2_dp_c11", 32'(dp1), 32'd0);
    tick(4);  chk("t2_dp_c7",  32'(dp1), 32'd1);
    tick(4);  chk("t2_dp_c3",  32'(dp1), 32'd0);
    tick(4);  chk1("t2_wait", 0, 0, 1, 0, 2, 0, 0);

    // 3: too many picks, out-of-range position
    spin_stop(3'd0, 6'b111111);
    chk1("t3_allpicks", 0, 1, 1, 0, 3, 1, 0);
    tick(16);
    spin_stop(3'd7, 6'b111111);
    chk1("t3_pos7", 0, 1, 1, 0, 4, 1, 0);
    tick(16);

    // 5: abort a show by spinning, then clear on the stop edge
    spin_stop(3'd3, 6'b001000);
    chk1("t5_hit", 1, 0, 2, 1, 5, 1, 0);
    tick(3);
    chk("t5_dp_show", 32'(dp1), 32'd1);
    running = 1'b1;
    tick(1);
    chk("t5_spin_dp", 32'(dp1), 32'd0);
    chk("t5_spin_over", 32'(go1), 32'd0);
    running = 1'b0;
    clear   = 1'b1;
    tick(1);
    clear = 1'b0;
    chk1("t5_clear", 0, 0, 0, 0, 0, 0, 0);
    tick(1);
    chk("t5_no_pulse", 32'(hit1 | miss1), 32'd0);

    // 4: full game, 5 hits then 3 misses
    for (int k = 0; k < 8; k++) begin
      spin_stop((k < 5) ? 3'd0 : 3'd1, 6'b000001);
      chk1($sformatf("t4_r%0d", k + 1), (k < 5), (k >= 5), (k < 5) ? k + 1 : 5,
           (k < 5) ? k + 1 : 0, k + 1, 1'b1, 1'b0);
      tick(16);
    end
    chk1("t4_over", 0, 0, 5, 0, 8, 1, 1);
    running = 1'b1; tick(2);
    running = 1'b0; tick(2);
    running = 1'b1; tick(1);
    running = 1'b0;
    chk1("t4_over_ign", 0, 0, 5, 0, 8, 1, 1);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk1("t4_clear", 0, 0, 0, 0, 0, 0, 0);

    // 6: small game instance, 3 hits, reset mid-show
    rst2 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      spin_stop(3'd5, 6'b100000);
      chk($sformatf("t6_hit%0d", k + 1),    32'(hit2),    32'd1);
      chk($sformatf("t6_score%0d", k + 1),  32'(score2),  32'(k + 1));
      chk($sformatf("t6_streak%0d", k + 1), 32'(streak2), 32'(k + 1));
      chk($sformatf("t6_rounds%0d", k + 1), 32'(rounds2), 32'(k + 1));
      if (k < 2) tick(16);
    end
    tick(2);
    chk("t6_dp_show", 32'(dp2), 32'd1);
    rst2 = 1'b1;
    tick(1);
    chk("t6_rst_vec", 32'({dp2, hit2, miss2, score2, streak2, rounds2, go2}), 32'd0);
    rst2 = 1'b0;
    tick(1);
    chk("t6_rst_wait", 32'({score2, go2}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
